sum16_sequencer: RTL and testbench
==================================

SUM16_SEQUENCER -- requirements
Module: sum16_sequencer

Interface
REQ-001 SHALL provide parameter OP_W, default 4, operand width in bits.
REQ-002 SHALL provide parameter N_OPS, default 16, operands per sum (legal range 2..255).
REQ-003 SHALL provide parameter SUM_W, default 8, result width in bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  begin a new summation; sampled only in IDLE, or in DONE together with sum_ready.
REQ-007 in_valid  input  1  in_data carries a valid operand.
REQ-008 in_data  input  OP_W  operand, unsigned.
REQ-009 in_ready  output  1  block accepts an operand this cycle.
REQ-010 sum  output  SUM_W  accumulated result, unsigned.
REQ-011 sum_valid  output  1  sum is final and held.
REQ-012 sum_ready  input  1  consumer takes the result.
REQ-013 overflow  output  1  carry out of SUM_W occurred during the current summation.
REQ-014 busy  output  1  high in LOAD and DONE.
REQ-015 count  output  8  operands accepted so far in the current summation.

Function
REQ-016 SHALL implement states IDLE, LOAD and DONE, encoded in one state register.
REQ-017 IDLE: in_ready=0, sum_valid=0; start=1 -> LOAD next cycle, with sum, count and overflow cleared to 0.
REQ-018 LOAD: in_ready=1, combinationally, independent of in_valid.
REQ-019 Operand transfer SHALL occur only on a cycle where in_valid=1 and in_ready=1; the transfer adds zero-extended in_data to sum and increments count.
REQ-020 in_valid=0 cycles in LOAD SHALL leave sum, count and overflow unchanged (no timeout).
REQ-021 Accumulation SHALL be modulo 2^SUM_W; overflow SHALL be set sticky on any carry out of bit SUM_W-1.
REQ-022 The transfer that makes count equal N_OPS SHALL move LOAD -> DONE; sum_valid=1 on the following cycle (1-cycle latency after the last operand).
REQ-023 DONE: in_ready=0; sum, overflow and count SHALL be held stable while sum_valid=1 and sum_ready=0.
REQ-024 DONE with sum_ready=1 and start=0 -> IDLE next cycle; sum retains its value, and sum_valid drops.
REQ-025 DONE with sum_ready=1 and start=1 -> LOAD directly, with sum, count and overflow cleared (back-to-back summations, no IDLE bubble).
REQ-026 start SHALL be ignored in LOAD, and in DONE without sum_ready.
REQ-027 sum_ready SHALL be ignored outside DONE.
REQ-028 With default parameters the maximum sum is 16*15=240, so overflow SHALL remain 0.

Reset
REQ-029 rst=1 SHALL force IDLE immediately, regardless of clk.
REQ-030 rst=1 SHALL force sum=0, count=0, overflow=0, sum_valid=0, in_ready=0 and busy=0 immediately, regardless of clk.
REQ-031 Reset mid-LOAD or mid-DONE SHALL discard the partial or held result; the first start after reset release begins a fresh summation.

Verification
REQ-032 Defaults; start; operands 1,2,3,4,0,5,6,7,8,9,10,11,12,13,14,15, one per cycle, in_valid held high -> sum=0x78 (120), overflow=0, sum_valid 1 cycle after 16th transfer.
REQ-033 Defaults; sixteen operands of 15 -> sum=0xF0 (240), overflow=0, count=16.
REQ-034 Same operands as REQ-032, in_valid toggled 1/0 every cycle, and sum_ready held 0 for 5 cycles in DONE -> sum=0x78 held stable, sum_valid held high until sum_ready.
REQ-035 start pulsed during LOAD at count=7 -> ignored; sum unaffected. start with sum_ready in DONE -> next cycle LOAD with count=0.
REQ-036 rst asserted between clock edges at count=9 -> outputs zeroed immediately; new summation of sixteen 1s after release -> sum=0x10.
REQ-037 SUM_W=7; sixteen operands of 15 -> sum=0x70 (240 mod 128), overflow=1.

Source files
------------

// File: rtl/sum16_sequencer.sv
// Sequential accumulator: collects N_OPS unsigned operands over a valid/ready
// handshake, then holds the sum until the consumer takes it.
module sum16_sequencer #(
  parameter int OP_W  = 4,
  parameter int N_OPS = 16,
  parameter int SUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_data,
  output logic             in_ready,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             overflow,
  output logic             busy,
  output logic [7:0]       count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam int AW = ((OP_W > SUM_W) ? OP_W : SUM_W) + 1;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [AW-1:0]    acc_ext;
  logic             xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    xfer       = in_valid && (state_q == LOAD);
    // Widened add: any bit at or above SUM_W is a carry out of the result.
    acc_ext    = AW'(sum_q) + AW'(in_data);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          sum_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      LOAD: begin
        if (xfer) begin
          sum_d      = acc_ext[SUM_W-1:0];
          count_d    = count_q + 8'd1;
          overflow_d = overflow_q | (|acc_ext[AW-1:SUM_W]);
          if (count_q == 8'(N_OPS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (sum_ready) begin
          if (start) begin
            state_d    = LOAD;
            sum_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == LOAD);
  assign sum_valid = (state_q == DONE);
  assign busy      = (state_q == LOAD) || (state_q == DONE);
  assign sum       = sum_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sum16_sequencer.sv
// Directed bench for sum16_sequencer: default instance plus a SUM_W=7 instance
// sharing the same stimulus to exercise overflow.
module tb_sum16_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, sum_ready;
  logic [3:0] in_data;
  logic       in_ready, sum_valid, overflow, busy;
  logic [7:0] sum, count;
  logic       in_ready7, sum_valid7, overflow7, busy7;
  logic [6:0] sum7;
  logic [7:0] count7;

  int checks = 0;
  int failures = 0;
  int ops [16] = '{1, 2, 3, 4, 0, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};

  always #5 clk = ~clk;

  sum16_sequencer #(.OP_W(4), .N_OPS(16), .SUM_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .overflow(overflow), .busy(busy), .count(count)
  );

  sum16_sequencer #(.OP_W(4), .N_OPS(16), .SUM_W(7)) dut7 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready7), .sum(sum7), .sum_valid(sum_valid7), .sum_ready(sum_ready),
    .overflow(overflow7), .busy(busy7), .count(count7)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int value, input logic valid);
    in_valid = valid;
    in_data  = 4'(value);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; sum_ready = 1'b0;
    #1;
    checks++;
    if ({sum_valid, in_ready, busy, overflow, sum, count} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs: got sv=%b rdy=%b busy=%b ovf=%b sum=%h cnt=%0d, want all 0",
               sum_valid, in_ready, busy, overflow, sum, count);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b in_ready=%b, want 0 0", busy, in_ready);
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL sum_ready_in_idle: busy=%b sum_valid=%b, want 0 0", busy, sum_valid);
    end
  endtask

  task automatic test_basic();
    do_start();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || count !== 8'd0 || sum !== 8'd0) begin
      failures++;
      $display("FAIL basic_load_entry: rdy=%b busy=%b cnt=%0d sum=%h, want 1 1 0 00",
               in_ready, busy, count, sum);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_data = 4'(ops[i]);
      tick();
    end
    checks++;
    if (sum_valid !== 1'b0 || count !== 8'd15 || sum !== 8'd105) begin
      failures++;
      $display("FAIL basic_before_last: sv=%b cnt=%0d sum=%0d, want 0 15 105",
               sum_valid, count, sum);
    end
    in_data = 4'(ops[15]);
    tick();
    in_valid = 1'b0;
    checks++;
    if (sum_valid !== 1'b1 || sum !== 8'h78 || overflow !== 1'b0 || count !== 8'd16 ||
        in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_done: sv=%b sum=%h ovf=%b cnt=%0d rdy=%b busy=%b, want 1 78 0 16 0 1",
               sum_valid, sum, overflow, count, in_ready, busy);
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    checks++;
    if (sum_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h78) begin
      failures++;
      $display("FAIL basic_to_idle: sv=%b busy=%b sum=%h, want 0 0 78", sum_valid, busy, sum);
    end
  endtask

  task automatic test_max_overflow();
    do_start();
    for (int i = 0; i < 16; i++) feed(15, 1'b1);
    checks++;
    if (sum !== 8'hF0 || overflow !== 1'b0 || count !== 8'd16 || sum_valid !== 1'b1) begin
      failures++;
      $display("FAIL max_sum8: sum=%h ovf=%b cnt=%0d sv=%b, want F0 0 16 1",
               sum, overflow, count, sum_valid);
    end
    checks++;
    if (sum7 !== 7'h70 || overflow7 !== 1'b1 || sum_valid7 !== 1'b1) begin
      failures++;
      $display("FAIL max_sum7: sum=%h ovf=%b sv=%b, want 70 1 1", sum7, overflow7, sum_valid7);
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  task automatic test_gaps_hold();
    do_start();
    for (int i = 0; i < 16; i++) begin
      feed(ops[i], 1'b1);
      if (i < 15) begin
        sum_ready = (i == 3);
        feed(15, 1'b0);
        sum_ready = 1'b0;
      end
      if (i == 3) begin
        checks++;
        if (count !== 8'd4 || sum !== 8'd10 || busy !== 1'b1) begin
          failures++;
          $display("FAIL gap_no_change: cnt=%0d sum=%0d busy=%b, want 4 10 1", count, sum, busy);
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (sum_valid !== 1'b1 || sum !== 8'h78 || count !== 8'd16 || overflow !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: sv=%b sum=%h cnt=%0d ovf=%b, want 1 78 16 0",
                 c, sum_valid, sum, count, overflow);
      end
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    checks++;
    if (sum_valid !== 1'b0 || sum !== 8'h78) begin
      failures++;
      $display("FAIL hold_release: sv=%b sum=%h, want 0 78", sum_valid, sum);
    end
  endtask

  task automatic test_start_ignored_back_to_back();
    do_start();
    for (int i = 0; i < 7; i++) feed(ops[i], 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (count !== 8'd7 || sum !== 8'd21 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL start_in_load: cnt=%0d sum=%0d rdy=%b, want 7 21 1", count, sum, in_ready);
    end
    for (int i = 7; i < 16; i++) feed(ops[i], 1'b1);
    checks++;
    if (sum !== 8'h78 || sum_valid !== 1'b1) begin
      failures++;
      $display("FAIL start_in_load_sum: sum=%h sv=%b, want 78 1", sum, sum_valid);
    end
    start = 1'b1;
    tick();
    checks++;
    if (sum_valid !== 1'b1 || sum !== 8'h78 || count !== 8'd16) begin
      failures++;
      $display("FAIL start_no_ready: sv=%b sum=%h cnt=%0d, want 1 78 16", sum_valid, sum, count);
    end
    sum_ready = 1'b1;
    tick();
    start = 1'b0;
    sum_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || sum_valid !== 1'b0 || count !== 8'd0 || sum !== 8'd0 ||
        overflow7 !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back: rdy=%b sv=%b cnt=%0d sum=%h ovf7=%b, want 1 0 0 00 0",
               in_ready, sum_valid, count, sum, overflow7);
    end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 9; i++) feed(1, 1'b1);
    checks++;
    if (count !== 8'd9 || sum !== 8'd9) begin
      failures++;
      $display("FAIL pre_reset: cnt=%0d sum=%0d, want 9 9", count, sum);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({sum_valid, in_ready, busy, overflow, sum, count} !== 20'h0) begin
      failures++;
      $display("FAIL async_reset: sv=%b rdy=%b busy=%b ovf=%b sum=%h cnt=%0d, want all 0",
               sum_valid, in_ready, busy, overflow, sum, count);
    end
    #2;
    rst = 1'b0;
    tick();
    do_start();
    for (int i = 0; i < 16; i++) feed(1, 1'b1);
    checks++;
    if (sum !== 8'h10 || count !== 8'd16 || sum_valid !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_sum: sum=%h cnt=%0d sv=%b ovf=%b, want 10 16 1 0",
               sum, count, sum_valid, overflow);
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded, want completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_max_overflow();
    test_gaps_hold();
    test_start_ignored_back_to_back();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
